// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared widths, register-zero constant and control-enable bit ordering
package decode_issue_pkg;
   localparam int XLEN_DEF   = 32;
   localparam int RA_W_DEF   = 5;
   localparam int FUNC_W_DEF = 10;
   localparam int LDC_W_DEF  = 3;
   localparam int CNT_W_DEF  = 16;
   localparam int REG_ZERO   = 0;
   localparam int EN_IMM         = 0;
   localparam int EN_REG_WR      = 1;
   localparam int EN_MEM_WR      = 2;
   localparam int EN_JMP         = 3;
   localparam int EN_UNCOND_JMP  = 4;
   localparam int EN_REL_REG_JMP = 5;
   localparam int N_EN           = 6;
   typedef logic [N_EN-1:0] en_vec_t;
endpackage

// File: rtl/decode_issue_stage_operand_fwd_mux.sv
// operand_fwd_mux: picks EX result, MEM result or register-file data for one source operand
module operand_fwd_mux
   import decode_issue_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RA_W = RA_W_DEF
) (
   input  logic [RA_W-1:0] i_src,
   input  logic [XLEN-1:0] i_rf_data,
   input  logic [RA_W-1:0] i_ex_a2,
   input  logic            i_ex_wr,
   input  logic            i_ex_is_load,
   input  logic [XLEN-1:0] i_ex_result,
   input  logic [RA_W-1:0] i_mem_a2,
   input  logic            i_mem_wr,
   input  logic [XLEN-1:0] i_mem_result,
   output logic [XLEN-1:0] o_data
);
   logic w_nz;
   logic w_ex_hit;
   logic w_mem_hit;
   // a load in EX has no data yet, so only ALU results are bypassed from EX
   always_comb begin
      w_nz      = i_src != RA_W'(REG_ZERO);
      w_ex_hit  = i_ex_wr && i_ex_a2 == i_src && !i_ex_is_load;
      w_mem_hit = i_mem_wr && i_mem_a2 == i_src;
      o_data    = !w_nz ? '0 : w_ex_hit ? i_ex_result : w_mem_hit ? i_mem_result : i_rf_data;
   end
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: operand forwarding, load-use stall and registered issue to execute
module decode_issue_stage
   import decode_issue_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int RA_W   = RA_W_DEF,
   parameter int FUNC_W = FUNC_W_DEF,
   parameter int LDC_W  = LDC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RA_W-1:0]   dec_a0,
   input  logic [RA_W-1:0]   dec_a1,
   input  logic [RA_W-1:0]   dec_a2,
   input  logic [XLEN-1:0]   dec_imm,
   input  logic [FUNC_W-1:0] dec_func,
   input  logic [LDC_W-1:0]  dec_ld_code,
   input  logic              dec_en_imm,
   input  logic              dec_en_reg_wr,
   input  logic              dec_en_mem_wr,
   input  logic              dec_en_jmp,
   input  logic              dec_en_uncond_jmp,
   input  logic              dec_en_rel_reg_jmp,
   input  logic [XLEN-1:0]   d0,
   input  logic [XLEN-1:0]   d1,
   input  logic [RA_W-1:0]   ex_a2,
   input  logic              ex_wr,
   input  logic              ex_is_load,
   input  logic [XLEN-1:0]   ex_result,
   input  logic [RA_W-1:0]   mem_a2,
   input  logic              mem_wr,
   input  logic [XLEN-1:0]   mem_result,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   alu_data1,
   output logic [XLEN-1:0]   alu_data2,
   output logic [XLEN-1:0]   data_to_mem,
   output logic [XLEN-1:0]   imm,
   output logic [FUNC_W-1:0] func,
   output logic [LDC_W-1:0]  ld_code,
   output logic [RA_W-1:0]   a2,
   output logic              en_imm,
   output logic              en_reg_wr,
   output logic              en_mem_wr,
   output logic              en_jmp,
   output logic              en_uncond_jmp,
   output logic              en_rel_reg_jmp,
   output logic [RA_W-1:0]   a2_hazard,
   output logic [CNT_W-1:0]  stall_cnt
);
   logic [XLEN-1:0]   w_src1;
   logic [XLEN-1:0]   w_src2;
   logic              w_load_use;
   logic              w_can_adv;
   logic              w_capture;
   logic              w_hold;
   en_vec_t           w_en_next;
   logic              r_valid;
   en_vec_t           r_en;
   logic [XLEN-1:0]   r_alu1;
   logic [XLEN-1:0]   r_alu2;
   logic [XLEN-1:0]   r_dmem;
   logic [XLEN-1:0]   r_imm;
   logic [FUNC_W-1:0] r_func;
   logic [LDC_W-1:0]  r_ld_code;
   logic [RA_W-1:0]   r_a2;
   logic [CNT_W-1:0]  r_stall_cnt;

   operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd0 (
      .i_src(dec_a0), .i_rf_data(d0), .i_ex_a2(ex_a2), .i_ex_wr(ex_wr),
      .i_ex_is_load(ex_is_load), .i_ex_result(ex_result), .i_mem_a2(mem_a2),
      .i_mem_wr(mem_wr), .i_mem_result(mem_result), .o_data(w_src1)
   );

   operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd1 (
      .i_src(dec_a1), .i_rf_data(d1), .i_ex_a2(ex_a2), .i_ex_wr(ex_wr),
      .i_ex_is_load(ex_is_load), .i_ex_result(ex_result), .i_mem_a2(mem_a2),
      .i_mem_wr(mem_wr), .i_mem_result(mem_result), .o_data(w_src2)
   );

   // hazard detection, handshake and the packed control-enable vector
   always_comb begin
      w_load_use = in_valid && ex_wr && ex_is_load && ex_a2 != RA_W'(REG_ZERO) &&
                   (ex_a2 == dec_a0 || (ex_a2 == dec_a1 && (!dec_en_imm || dec_en_mem_wr)));
      w_can_adv  = !r_valid || out_ready;
      w_hold     = r_valid && !out_ready;
      in_ready   = !w_load_use && w_can_adv;
      w_capture  = in_valid && in_ready && !flush;
      w_en_next                 = '0;
      w_en_next[EN_IMM]         = dec_en_imm;
      w_en_next[EN_REG_WR]      = dec_en_reg_wr;
      w_en_next[EN_MEM_WR]      = dec_en_mem_wr;
      w_en_next[EN_JMP]         = dec_en_jmp;
      w_en_next[EN_UNCOND_JMP]  = dec_en_uncond_jmp;
      w_en_next[EN_REL_REG_JMP] = dec_en_rel_reg_jmp;
   end

   // issue register: flush beats capture beats hold; bubbles and idle clear only valid and enables
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid   <= 1'b0;
         r_en      <= '0;
         r_alu1    <= '0;
         r_alu2    <= '0;
         r_dmem    <= '0;
         r_imm     <= '0;
         r_func    <= '0;
         r_ld_code <= '0;
         r_a2      <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_en    <= '0;
      end else if (w_capture) begin
         r_valid   <= 1'b1;
         r_en      <= w_en_next;
         r_alu1    <= w_src1;
         r_alu2    <= dec_en_imm ? dec_imm : w_src2;
         r_dmem    <= w_src2;
         r_imm     <= dec_imm;
         r_func    <= dec_func;
         r_ld_code <= dec_ld_code;
         r_a2      <= dec_a2;
      end else if (!w_hold) begin
         r_valid <= 1'b0;
         r_en    <= '0;
      end
   end

   // saturating count of load-use stall cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_stall_cnt <= '0;
      else if (w_load_use && !flush && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign out_valid      = r_valid;
   assign alu_data1      = r_alu1;
   assign alu_data2      = r_alu2;
   assign data_to_mem    = r_dmem;
   assign imm            = r_imm;
   assign func           = r_func;
   assign ld_code        = r_ld_code;
   assign a2             = r_a2;
   assign en_imm         = r_en[EN_IMM];
   assign en_reg_wr      = r_en[EN_REG_WR];
   assign en_mem_wr      = r_en[EN_MEM_WR];
   assign en_jmp         = r_en[EN_JMP];
   assign en_uncond_jmp  = r_en[EN_UNCOND_JMP];
   assign en_rel_reg_jmp = r_en[EN_REL_REG_JMP];
   assign a2_hazard      = dec_a2;
   assign stall_cnt      = r_stall_cnt;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: vector table plus hand sequences, scoreboard of expected issues
module tb_decode_issue_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [4:0]  dec_a0, dec_a1, dec_a2;
   logic [31:0] dec_imm;
   logic [9:0]  dec_func;
   logic [2:0]  dec_ld_code;
   logic        dec_en_imm, dec_en_reg_wr, dec_en_mem_wr, dec_en_jmp, dec_en_uncond_jmp, dec_en_rel_reg_jmp;
   logic [31:0] d0, d1;
   logic [4:0]  ex_a2;
   logic        ex_wr, ex_is_load;
   logic [31:0] ex_result;
   logic [4:0]  mem_a2;
   logic        mem_wr;
   logic [31:0] mem_result;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] alu_data1, alu_data2, data_to_mem, imm;
   logic [9:0]  func;
   logic [2:0]  ld_code;
   logic [4:0]  a2;
   logic        en_imm, en_reg_wr, en_mem_wr, en_jmp, en_uncond_jmp, en_rel_reg_jmp;
   logic [4:0]  a2_hazard;
   logic [15:0] stall_cnt;

   typedef struct {
      logic [4:0]  a0, a1, a2;
      logic [31:0] imm;
      logic        en_imm, en_mem_wr, en_reg_wr;
      logic [31:0] d0, d1;
      logic [4:0]  ex_a2;
      logic        ex_wr, ex_ld;
      logic [31:0] ex_res;
      logic [4:0]  mem_a2;
      logic        mem_wr;
      logic [31:0] mem_res;
      logic [31:0] e_alu1, e_alu2, e_dmem;
   } vec_t;

   typedef struct {
      logic [31:0] alu1, alu2, dmem, imm;
      logic [4:0]  a2;
      logic        en_reg_wr, en_mem_wr, en_imm;
   } exp_t;

   exp_t q[$];
   vec_t v[6];
   int   total = 0;
   int   passed = 0;

   decode_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dec_a0(dec_a0), .dec_a1(dec_a1), .dec_a2(dec_a2), .dec_imm(dec_imm),
      .dec_func(dec_func), .dec_ld_code(dec_ld_code), .dec_en_imm(dec_en_imm),
      .dec_en_reg_wr(dec_en_reg_wr), .dec_en_mem_wr(dec_en_mem_wr), .dec_en_jmp(dec_en_jmp),
      .dec_en_uncond_jmp(dec_en_uncond_jmp), .dec_en_rel_reg_jmp(dec_en_rel_reg_jmp),
      .d0(d0), .d1(d1), .ex_a2(ex_a2), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
      .ex_result(ex_result), .mem_a2(mem_a2), .mem_wr(mem_wr), .mem_result(mem_result),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .data_to_mem(data_to_mem), .imm(imm),
      .func(func), .ld_code(ld_code), .a2(a2), .en_imm(en_imm), .en_reg_wr(en_reg_wr),
      .en_mem_wr(en_mem_wr), .en_jmp(en_jmp), .en_uncond_jmp(en_uncond_jmp),
      .en_rel_reg_jmp(en_rel_reg_jmp), .a2_hazard(a2_hazard), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t t);
      in_valid = 1'b1;
      dec_a0 = t.a0; dec_a1 = t.a1; dec_a2 = t.a2; dec_imm = t.imm;
      dec_en_imm = t.en_imm; dec_en_mem_wr = t.en_mem_wr; dec_en_reg_wr = t.en_reg_wr;
      d0 = t.d0; d1 = t.d1;
      ex_a2 = t.ex_a2; ex_wr = t.ex_wr; ex_is_load = t.ex_ld; ex_result = t.ex_res;
      mem_a2 = t.mem_a2; mem_wr = t.mem_wr; mem_result = t.mem_res;
   endtask

   task automatic push(input vec_t t);
      exp_t e;
      e.alu1 = t.e_alu1; e.alu2 = t.e_alu2; e.dmem = t.e_dmem; e.imm = t.imm; e.a2 = t.a2;
      e.en_reg_wr = t.en_reg_wr; e.en_mem_wr = t.en_mem_wr; e.en_imm = t.en_imm;
      q.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      if (q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = q.pop_front();
         chk({tag, "_alu1"}, 64'(alu_data1), 64'(e.alu1));
         chk({tag, "_alu2"}, 64'(alu_data2), 64'(e.alu2));
         chk({tag, "_dmem"}, 64'(data_to_mem), 64'(e.dmem));
         chk({tag, "_imm"}, 64'(imm), 64'(e.imm));
         chk({tag, "_a2"}, 64'(a2), 64'(e.a2));
         chk({tag, "_en"}, {61'd0, en_reg_wr, en_mem_wr, en_imm}, {61'd0, e.en_reg_wr, e.en_mem_wr, e.en_imm});
      end
   endtask

   initial begin
      vec_t h;
      v[0] = '{5'd1, 5'd0, 5'd2, 32'd5, 1'b1, 1'b0, 1'b1, 32'd7, 32'd9, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd7, 32'd5, 32'd0};
      v[1] = '{5'd3, 5'd6, 5'd11, 32'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'h66, 5'd3, 1'b1, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB, 32'hAA, 32'h66, 32'h66};
      v[2] = '{5'd5, 5'd7, 5'd12, 32'd0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h20, 5'd9, 1'b1, 1'b0, 32'd1, 5'd7, 1'b1, 32'hCC, 32'h10, 32'hCC, 32'hCC};
      v[3] = '{5'd0, 5'd0, 5'd13, 32'd3, 1'b0, 1'b0, 1'b0, 32'h123, 32'h456, 5'd0, 1'b1, 1'b0, 32'hFF, 5'd0, 1'b1, 32'hEE, 32'd0, 32'd0, 32'd0};
      v[4] = '{5'd8, 5'd8, 5'd14, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h55, 32'h77, 5'd8, 1'b0, 1'b0, 32'd1, 5'd8, 1'b0, 32'h44, 32'h55, 32'hFFFFFFFF, 32'h77};
      v[5] = '{5'd2, 5'd4, 5'd15, 32'h30, 1'b1, 1'b0, 1'b0, 32'd2, 32'd3, 5'd4, 1'b1, 1'b1, 32'h11, 5'd4, 1'b1, 32'h99, 32'd2, 32'h30, 32'h99};
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      dec_a0 = '0; dec_a1 = '0; dec_a2 = '0; dec_imm = '0; dec_func = 10'h2A; dec_ld_code = 3'd5;
      dec_en_imm = 0; dec_en_reg_wr = 0; dec_en_mem_wr = 0; dec_en_jmp = 0; dec_en_uncond_jmp = 0; dec_en_rel_reg_jmp = 0;
      d0 = '0; d1 = '0; ex_a2 = '0; ex_wr = 0; ex_is_load = 0; ex_result = '0; mem_a2 = '0; mem_wr = 0; mem_result = '0;
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_alu1", 64'(alu_data1), 64'd0);
      chk("rst_func", 64'(func), 64'd0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         apply(v[i]);
         #1;
         chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
         push(v[i]);
         step();
         pop_cmp($sformatf("vec%0d", i));
      end
      chk("vec_func", 64'(func), 64'h2A);
      chk("vec_ld_code", 64'(ld_code), 64'd5);
      in_valid = 1'b0;
      step();
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_en_imm", 64'(en_imm), 64'd0);
      chk("idle_data_hold", 64'(alu_data2), 64'h30);
      h = v[1];
      h.a0 = 5'd1; h.a1 = 5'd4; h.a2 = 5'd20; h.en_imm = 1'b0; h.en_reg_wr = 1'b1;
      h.ex_a2 = 5'd4; h.ex_wr = 1'b1; h.ex_ld = 1'b1; h.mem_wr = 1'b0;
      apply(h);
      #1;
      chk("lu1_in_ready", 64'(in_ready), 64'd0);
      chk("lu1_a2_hazard", 64'(a2_hazard), 64'd20);
      step();
      chk("lu1_out_valid", 64'(out_valid), 64'd0);
      chk("lu1_en_reg_wr", 64'(en_reg_wr), 64'd0);
      chk("lu1_stall_cnt", 64'(stall_cnt), 64'd1);
      dec_en_imm = 1'b1; dec_en_mem_wr = 1'b1;
      #1;
      chk("lu2_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("lu2_stall_cnt", 64'(stall_cnt), 64'd2);
      flush = 1'b1;
      step();
      chk("lu_flush_stall_cnt", 64'(stall_cnt), 64'd2);
      chk("lu_flush_out_valid", 64'(out_valid), 64'd0);
      flush = 1'b0;
      h = v[0];
      h.a0 = 5'd1; h.a1 = 5'd2; h.a2 = 5'd9; h.en_imm = 1'b0; h.en_reg_wr = 1'b1; h.en_mem_wr = 1'b0;
      h.d0 = 32'h111; h.d1 = 32'h222; h.imm = 32'h7;
      h.e_alu1 = 32'h111; h.e_alu2 = 32'h222; h.e_dmem = 32'h222;
      apply(h);
      push(h);
      step();
      pop_cmp("hold_cap");
      out_ready = 1'b0;
      d0 = 32'h999; dec_a2 = 5'd10; dec_en_reg_wr = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
         step();
         chk($sformatf("hold%0d_out_valid", c), 64'(out_valid), 64'd1);
         chk($sformatf("hold%0d_alu1", c), 64'(alu_data1), 64'h111);
         chk($sformatf("hold%0d_a2", c), 64'(a2), 64'd9);
         chk($sformatf("hold%0d_en_reg_wr", c), 64'(en_reg_wr), 64'd1);
      end
      flush = 1'b1;
      step();
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_en_reg_wr", 64'(en_reg_wr), 64'd0);
      flush = 1'b0;
      out_ready = 1'b1;
      apply(v[2]);
      push(v[2]);
      step();
      pop_cmp("post_flush");
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_alu1", 64'(alu_data1), 64'd0);
      chk("arst_en_reg_wr", 64'(en_reg_wr), 64'd0);
      chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
